mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single data/instruction memory bus between two requesters:
  - instruction fetch (IF, read-only);
  - the memory_access_unit (LSU, byte-lane read/write).
- Sits between both requesters and the bus slave.
- Registers each granted transaction and holds it stable until the slave signals ready.
- Returns registered read data with a one-cycle acknowledge.
- Guards against a hung slave with a timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enables are DATA_W/8 bits).
- LSU_STREAK_MAX, 4, consecutive LSU grants allowed while IF waits before IF is forced a grant.
- TIMEOUT_CYCLES, 255, BUSY cycles without bus_ready before the transaction is aborted with error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request, held until if_ack.
- if_addr  in  ADDR_W  IF read address.
- if_rdata  out  DATA_W  IF read data, valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse to IF.
- lsu_re  in  1  LSU read request (from the access unit's bus_re).
- lsu_we  in  DATA_W/8  LSU byte write enables (from the access unit's bus_we).
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_rdata  out  DATA_W  LSU read data, valid while lsu_ack=1.
- lsu_ack  out  1  one-cycle completion pulse to LSU.
- bus_re  out  1  slave read strobe.
- bus_we  out  DATA_W/8  slave byte write enables.
- bus_addr  out  ADDR_W  slave address.
- bus_wdata  out  DATA_W  slave write data.
- bus_rdata  in  DATA_W  slave read data, sampled when bus_ready=1.
- bus_ready  in  1  slave completion, may be high in the first BUSY cycle.
- bus_err  out  1  one-cycle pulse with the ack of a timed-out transaction.

Behaviour:
- Single clock domain.
- Reset:
  - all outputs 0, state IDLE, streak counter 0, timeout counter 0;
  - reset mid-transaction aborts it without any ack.
- LSU request is defined as lsu_re | (|lsu_we). If lsu_re and lsu_we are both asserted, the write wins and bus_re=0.
- Three-state FSM: IDLE, BUSY, RESP.
- IDLE:
  - no request: stay in IDLE.
  - Arbitration when a request is present:
    - LSU has priority;
    - exception: IF wins if if_req=1 and streak==LSU_STREAK_MAX.
  - On grant, latch owner, addr, we, re and wdata into registers, then go to BUSY.
  - Streak counter update on grant:
    - LSU grant while if_req=1: increment, saturating;
    - IF grant: clear;
    - LSU grant with if_req=0: clear.
- BUSY:
  - bus_re, bus_we, bus_addr and bus_wdata are driven from the latched registers only.
  - Requester input changes are ignored.
  - Timeout counter increments each BUSY cycle.
  - bus_ready=1: capture bus_rdata (read) or 0 (write) into the owner's rdata register, then go to RESP.
  - Counter reaches TIMEOUT_CYCLES with bus_ready=0: rdata=0, set the error flag, then go to RESP.
  - bus_ready in the same cycle as the timeout is treated as success.
- RESP:
  - Bus strobes are 0.
  - Owner's ack=1 for exactly one cycle; bus_err=1 in that cycle only if the transaction timed out.
  - Next state is IDLE. There is no same-cycle re-grant: one bubble cycle lets the requester drop its request.
- Latency: request visible in cycle N → BUSY in N+1 → ack in N+2 at best (zero slave wait states). Each slave wait state adds one cycle.
- Outside RESP, the rdata outputs hold their last value. if_ack and lsu_ack are never both 1.
- Requesters must hold their request and payload stable until ack. A request dropped before grant is simply not serviced.

Decomposition:
- Shared package/header holds:
  - state encodings ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_RESP=2'd2;
  - owner encodings OWN_IF=1'b0, OWN_LSU=1'b1.
  - Add these as an enum module alongside MEM_OP_ENUM and MEM_SEL_ENUM.
- One natural sub-module: arb_timeout_counter, a loadable counter with clear, enable and an expired flag, reusable for other bus masters.

Test Plan:
- Simultaneous if_req=1 (addr 0x100) and lsu_re=1 (addr 0x200), bus_ready tied 1, bus_rdata=0xDEADBEEF:
  - LSU gets the bus first; lsu_ack in cycle 2 with lsu_rdata=0xDEADBEEF;
  - then bus_addr=0x100 and if_ack follows.
- LSU write lsu_we=4'b0011, addr 0x40, wdata 0x12345678, bus_ready delayed 3 cycles:
  - bus_we=0011 and bus_wdata=0x12345678 held stable for 4 BUSY cycles;
  - lsu_ack 1 cycle later; lsu_rdata=0.
- IF and LSU requesting continuously with LSU_STREAK_MAX=4: grant order is LSU×4, IF, LSU×4, IF.
- bus_ready stuck 0 with TIMEOUT_CYCLES=8:
  - after 8 BUSY cycles, lsu_ack=1 and bus_err=1 for one cycle, rdata=0;
  - FSM back in IDLE and the next IF request is serviced normally.
- rst=1 asserted in the 2nd BUSY cycle of an IF read: next cycle all bus strobes are 0, if_ack never pulses, state is IDLE.
- Change lsu_addr from 0x200 to 0x300 during BUSY: bus_addr stays 0x200 until the transaction completes.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states and bus ownership.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    // Saturating increment used for the LSU streak counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val, input logic [7:0] max);
        return (val >= max) ? max : val + 8'd1;
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Loadable up-counter with clear and enable; flags the cycle in which an
// enabled count reaches LIMIT. Reusable by any bus master needing a watchdog.
module arb_timeout_counter #(
    parameter int LIMIT = 255,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] TOP  = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && count_q != TOP) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The increment happening this cycle is the one that reaches LIMIT.
    assign expired_o = en_i && (count_q >= LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (instruction fetch, load/store unit) for a single memory
// bus slave: registered grant, hold-until-ready, one-cycle ack, hung-slave timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LSU_STREAK_MAX = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                lsu_re,
    input  logic [DATA_W/8-1:0] lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_ack,
    output logic                bus_re,
    output logic [DATA_W/8-1:0] bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ready,
    output logic                bus_err
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [7:0] STREAK_MAX = 8'(LSU_STREAK_MAX);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     we_q, we_d;
    logic                re_q, re_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                err_q, err_d;
    logic [7:0]          streak_q, streak_d;

    logic lsu_req;
    logic grant_if;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;
    logic [DATA_W-1:0] resp_data;

    assign lsu_req  = lsu_re | (|lsu_we);
    // IF only preempts a pending LSU request once the LSU streak is exhausted.
    assign grant_if = if_req & (~lsu_req | (streak_q == STREAK_MAX));

    arb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (timer_clr),
        .en_i       (timer_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .expired_o  (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        re_d        = re_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        err_d       = err_q;
        streak_d    = streak_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        resp_data   = re_q ? bus_rdata : '0;

        case (state_q)
            ARB_IDLE: begin
                timer_clr = 1'b1;
                err_d     = 1'b0;
                if (grant_if) begin
                    state_d  = ARB_BUSY;
                    owner_d  = OWN_IF;
                    addr_d   = if_addr;
                    we_d     = '0;
                    re_d     = 1'b1;
                    wdata_d  = '0;
                    streak_d = '0;
                end else if (lsu_req) begin
                    state_d  = ARB_BUSY;
                    owner_d  = OWN_LSU;
                    addr_d   = lsu_addr;
                    we_d     = lsu_we;
                    re_d     = lsu_re & ~(|lsu_we);
                    wdata_d  = lsu_wdata;
                    streak_d = if_req ? sat_inc8(streak_q, STREAK_MAX) : '0;
                end
            end
            ARB_BUSY: begin
                timer_en = 1'b1;
                // A ready arriving on the timeout cycle still counts as success.
                if (bus_ready || timer_expired) begin
                    state_d = ARB_RESP;
                    err_d   = ~bus_ready;
                    if (!bus_ready) begin
                        resp_data = '0;
                    end
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = resp_data;
                    end else begin
                        lsu_rdata_d = resp_data;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            we_q        <= '0;
            re_q        <= 1'b0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
            err_q       <= 1'b0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            re_q        <= re_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            err_q       <= err_d;
            streak_q    <= streak_d;
        end
    end

    assign bus_re    = (state_q == ARB_BUSY) & re_q;
    assign bus_we    = (state_q == ARB_BUSY) ? we_q : '0;
    assign bus_addr  = (state_q == ARB_BUSY) ? addr_q : '0;
    assign bus_wdata = (state_q == ARB_BUSY) ? wdata_q : '0;
    assign if_ack    = (state_q == ARB_RESP) & (owner_q == OWN_IF);
    assign lsu_ack   = (state_q == ARB_RESP) & (owner_q == OWN_LSU);
    assign bus_err   = (state_q == ARB_RESP) & err_q;
    assign if_rdata  = if_rdata_q;
    assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (streak limit 4, timeout 8).
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              lsu_re;
    logic [3:0]        lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_ack;
    logic              bus_re;
    logic [3:0]        bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;
    logic              bus_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .LSU_STREAK_MAX (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .lsu_re    (lsu_re),
        .lsu_we    (lsu_we),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_rdata (lsu_rdata),
        .lsu_ack   (lsu_ack),
        .bus_re    (bus_re),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .bus_err   (bus_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One line per completed transaction.
    always @(negedge clk) begin
        if (if_ack || lsu_ack) begin
            $display("[%0t] ack %s if_rdata=0x%08h lsu_rdata=0x%08h err=%0b",
                     $time, if_ack ? "IF " : "LSU", if_rdata, lsu_rdata, bus_err);
        end
    end

    initial begin
        int n_acks;
        logic got_own;
        logic exp_own;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        lsu_re = 1'b0; lsu_we = '0; lsu_addr = '0; lsu_wdata = '0;
        bus_rdata = '0; bus_ready = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_eq("rst_bus_re",  bus_re,  0);
        check_eq("rst_bus_we",  bus_we,  0);
        check_eq("rst_if_ack",  if_ack,  0);
        check_eq("rst_lsu_ack", lsu_ack, 0);
        check_eq("rst_bus_err", bus_err, 0);
        check_eq("rst_lsu_rd",  lsu_rdata, 0);

        // Simultaneous IF and LSU read: LSU first, then IF
        bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h100;
        lsu_re = 1'b1; lsu_addr = 32'h200;
        tick();
        check_eq("t1_busy_addr", bus_addr, 32'h200);
        check_eq("t1_busy_re",   bus_re,   1);
        tick();
        check_eq("t1_lsu_ack",   lsu_ack,  1);
        check_eq("t1_if_ack0",   if_ack,   0);
        check_eq("t1_lsu_rdata", lsu_rdata, 32'hDEADBEEF);
        lsu_re = 1'b0;
        tick();
        check_eq("t1_bubble_re", bus_re, 0);
        tick();
        check_eq("t1_if_addr",   bus_addr, 32'h100);
        tick();
        check_eq("t1_if_ack",    if_ack,   1);
        check_eq("t1_if_rdata",  if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        tick();

        // LSU byte write with 3 slave wait states
        bus_ready = 1'b0;
        lsu_we = 4'b0011; lsu_addr = 32'h40; lsu_wdata = 32'h12345678;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_we_%0d", i),    bus_we,    4'b0011);
            check_eq($sformatf("t2_wdata_%0d", i), bus_wdata, 32'h12345678);
            check_eq($sformatf("t2_re_%0d", i),    bus_re,    0);
            check_eq($sformatf("t2_ack0_%0d", i),  lsu_ack,   0);
            bus_ready = (i == 3);
            tick();
        end
        check_eq("t2_lsu_ack",   lsu_ack,   1);
        check_eq("t2_lsu_rdata", lsu_rdata, 0);
        check_eq("t2_resp_we",   bus_we,    0);
        lsu_we = '0; bus_ready = 1'b0;
        tick();

        // Address change during BUSY is ignored
        lsu_re = 1'b1; lsu_addr = 32'h200; bus_rdata = 32'h0BADF00D;
        tick();
        check_eq("t6_addr_a", bus_addr, 32'h200);
        lsu_addr = 32'h300;
        tick();
        check_eq("t6_addr_b", bus_addr, 32'h200);
        bus_ready = 1'b1;
        tick();
        check_eq("t6_ack",   lsu_ack,   1);
        check_eq("t6_rdata", lsu_rdata, 32'h0BADF00D);
        lsu_re = 1'b0;
        tick();

        // Continuous requests from both: LSU x4, IF, LSU x4, IF
        if_req = 1'b1; if_addr = 32'h180;
        lsu_re = 1'b1; lsu_addr = 32'h280;
        n_acks = 0;
        for (int c = 0; c < 80 && n_acks < 10; c++) begin
            tick();
            check_eq("t3_excl", {if_ack, lsu_ack} == 2'b11, 0);
            if (if_ack || lsu_ack) begin
                got_own = lsu_ack;
                exp_own = ((n_acks % 5) != 4);
                check_eq($sformatf("t3_grant_%0d", n_acks), got_own, exp_own);
                n_acks++;
            end
        end
        if_req = 1'b0; lsu_re = 1'b0;
        check_eq("t3_ack_count", n_acks, 10);
        tick();

        // Hung slave: timeout after 8 BUSY cycles
        bus_ready = 1'b0; bus_rdata = 32'h55AA55AA;
        lsu_re = 1'b1; lsu_addr = 32'h80;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t4_busy_re_%0d", i), bus_re, 1);
            check_eq($sformatf("t4_noack_%0d", i), lsu_ack, 0);
            tick();
        end
        check_eq("t4_ack",   lsu_ack,   1);
        check_eq("t4_err",   bus_err,   1);
        check_eq("t4_rdata", lsu_rdata, 0);
        lsu_re = 1'b0;
        tick();
        check_eq("t4_err_clr", bus_err, 0);
        check_eq("t4_ack_clr", lsu_ack, 0);
        if_req = 1'b1; if_addr = 32'h104;
        bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        check_eq("t4_if_addr", bus_addr, 32'h104);
        tick();
        check_eq("t4_if_ack",   if_ack,   1);
        check_eq("t4_if_err",   bus_err,  0);
        check_eq("t4_if_rdata", if_rdata, 32'hCAFEF00D);
        if_req = 1'b0;
        tick();

        // Reset in the 2nd BUSY cycle of an IF read
        bus_ready = 1'b0;
        if_req = 1'b1; if_addr = 32'h108;
        tick();
        tick();
        check_eq("t5_busy_re", bus_re, 1);
        rst = 1'b1;
        tick();
        check_eq("t5_re",    bus_re,   0);
        check_eq("t5_we",    bus_we,   0);
        check_eq("t5_addr",  bus_addr, 0);
        check_eq("t5_ack",   if_ack,   0);
        check_eq("t5_rdata", if_rdata, 0);
        rst = 1'b0; if_req = 1'b0; bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("t5_noack_%0d", i), if_ack, 0);
            check_eq($sformatf("t5_idle_%0d", i), bus_re, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
